// File: rtl/sme_feeder_if.sv
// -----------------------------------------------------------------------------
// sme_feeder_if
//   Bus bundle between a byte producer, the SME job feeder and the SME.
//
//   Handshake rules:
//     Producer side: a byte (in_data/in_is_pattern/in_last) is transferred on
//       every rising clk edge where in_valid && in_ready; in_ready never depends
//       on in_valid in the same cycle.
//     SME side: there is no back-pressure. Whenever sme_isstring or
//       sme_ispattern is 1, the SME consumes sme_chardata at that edge.
//       sme_valid is a one-cycle result pulse from the SME.
//
//   Modports:
//     slave  - the feeder (consumes producer bytes, drives the SME strobes)
//     master - the environment (producer + SME)
// -----------------------------------------------------------------------------
interface sme_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_is_pattern;
  logic       in_last;
  logic [7:0] sme_chardata;
  logic       sme_isstring;
  logic       sme_ispattern;
  logic       sme_valid;

  modport slave (
    input  in_valid, in_data, in_is_pattern, in_last, sme_valid,
    output in_ready, sme_chardata, sme_isstring, sme_ispattern
  );

  modport master (
    output in_valid, in_data, in_is_pattern, in_last, sme_valid,
    input  in_ready, sme_chardata, sme_isstring, sme_ispattern
  );
endinterface

// File: rtl/sme_feeder.sv
// -----------------------------------------------------------------------------
// sme_feeder
//   Upstream job feeder for the string-match engine. Producer bytes are
//   buffered in a FIFO as {pattern,last,data}. Once a complete job (string
//   bytes followed by pattern bytes ending in last) is buffered, it is replayed
//   to the SME as one gap-free burst. After a job's final pattern byte the
//   feeder waits for the SME's sme_valid pulse and presents the next job's
//   first byte combinationally in that same cycle.
//
//   Parameters:
//     DEPTH    FIFO entries (power of two, must hold one STR_MAX+PAT_MAX job)
//     STR_MAX  max string bytes per job (enforced only with SME_FEEDER_CHECK_EN)
//     PAT_MAX  max pattern bytes per job (enforced only with SME_FEEDER_CHECK_EN)
//
//   Ports:
//     clk        clock
//     reset      asynchronous, active-high reset
//     bus        sme_feeder_if.slave (producer handshake + SME strobes)
//     busy       state is SEND or WAIT
//     underrun   sticky: sme_valid seen in WAIT with no complete job buffered
//     err_len    sticky: job length violation (always 0 without the macro)
//     dbg_state  current FSM state (0=FIRST, 1=SEND, 2=WAIT)
//
//   Configuration macro: SME_FEEDER_CHECK_EN
//     Defined: per-job byte counters truncate overlong string/pattern segments
//     and set err_len. Undefined: bytes are stored exactly as received.
// -----------------------------------------------------------------------------
module sme_feeder #(
  parameter int DEPTH   = 64,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  sme_feeder_if.slave bus,
  output logic        busy,
  output logic        underrun,
  output logic        err_len,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < STR_MAX + PAT_MAX)) begin : g_bad_cfg
      $error("sme_feeder: DEPTH must be a power of two holding one full job");
    end
  endgenerate

  typedef struct packed {
    logic       pattern;
    logic       last;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   job_cnt;
  logic          full;
  logic          accept;
  logic          store;
  logic          start;
  logic          drive;
  logic          head_ends;
  logic          job_inc, job_dec;
  logic          job_nz;
  logic          underrun_set;

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one wrap bit, so full = same index, different lap.
  // in_ready depends only on registered pointers, so a pop cannot make room
  // for a write in the same cycle.
  // ---------------------------------------------------------------------------
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign head_ends    = head.pattern && head.last;

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

`ifdef SME_FEEDER_CHECK_EN
  localparam int SCW = $clog2(STR_MAX + 1);
  localparam int PCW = $clog2(PAT_MAX + 1);
  localparam logic [SCW-1:0] STR_LIM  = SCW'(STR_MAX);
  localparam logic [PCW-1:0] PAT_LAST = PCW'(PAT_MAX - 1);

  logic [SCW-1:0] str_cnt;
  logic [PCW-1:0] pat_cnt;
  logic           discard;
  logic           str_inc, pat_inc, cnt_clr;
  logic           discard_set, discard_clr, err_set;

  // Length policing. After a forced last, the remainder of the job (up to the
  // producer's own in_last) is accepted but dropped.
  always_comb begin
    store       = 1'b0;
    wr_entry    = '{pattern: bus.in_is_pattern,
                    last:    bus.in_is_pattern && bus.in_last,
                    data:    bus.in_data};
    str_inc     = 1'b0;
    pat_inc     = 1'b0;
    cnt_clr     = 1'b0;
    discard_set = 1'b0;
    discard_clr = 1'b0;
    err_set     = 1'b0;
    if (accept) begin
      if (discard) begin
        err_set = 1'b1;
        if (bus.in_is_pattern && bus.in_last) begin
          discard_clr = 1'b1;
          cnt_clr     = 1'b1;
        end
      end else if (!bus.in_is_pattern) begin
        if (str_cnt == STR_LIM) begin
          err_set = 1'b1;
        end else begin
          store   = 1'b1;
          str_inc = 1'b1;
        end
      end else begin
        store = 1'b1;
        if (bus.in_last) begin
          cnt_clr = 1'b1;
        end else if (pat_cnt == PAT_LAST) begin
          wr_entry.last = 1'b1;
          err_set       = 1'b1;
          discard_set   = 1'b1;
          cnt_clr       = 1'b1;
        end else begin
          pat_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_cnt <= '0;
      pat_cnt <= '0;
      discard <= 1'b0;
      err_len <= 1'b0;
    end else begin
      if (cnt_clr) begin
        str_cnt <= '0;
        pat_cnt <= '0;
      end else begin
        if (str_inc) str_cnt <= str_cnt + SCW'(1);
        if (pat_inc) pat_cnt <= pat_cnt + PCW'(1);
      end
      if (discard_set)      discard <= 1'b1;
      else if (discard_clr) discard <= 1'b0;
      if (err_set) err_len <= 1'b1;
    end
  end
`else
  // in_last on a string byte carries no meaning and is not stored.
  always_comb begin
    store    = accept;
    wr_entry = '{pattern: bus.in_is_pattern,
                 last:    bus.in_is_pattern && bus.in_last,
                 data:    bus.in_data};
  end

  assign err_len = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Complete-job counter: only complete jobs are ever started, so a burst can
  // never run the FIFO dry.
  // ---------------------------------------------------------------------------
  assign job_inc = store && wr_entry.pattern && wr_entry.last;
  assign job_dec = drive && head_ends;
  assign job_nz  = (job_cnt != '0);

  // ---------------------------------------------------------------------------
  // FSM next state / outputs. The sme_valid -> sme_* path is combinational so
  // the SME sees the next job's first byte in its own valid cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    underrun_set = 1'b0;
    case (state)
      ST_FIRST: start = job_nz;
      ST_SEND:  start = 1'b0;
      ST_WAIT: begin
        if (bus.sme_valid) begin
          if (job_nz) begin
            start = 1'b1;
          end else begin
            underrun_set = 1'b1;
            state_nxt    = ST_FIRST;
          end
        end
      end
      default:  state_nxt = ST_FIRST;
    endcase

    drive = start || (state == ST_SEND);
    // A single-byte job pops its last byte on the start cycle and goes
    // straight to WAIT.
    if (drive) state_nxt = head_ends ? ST_WAIT : ST_SEND;

    bus.sme_chardata  = drive ? head.data : 8'h00;
    bus.sme_isstring  = drive && !head.pattern;
    bus.sme_ispattern = drive && head.pattern;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FIRST;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      job_cnt  <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (store) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (drive) rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({job_inc, job_dec})
        2'b10:   job_cnt <= job_cnt + (AW+1)'(1);
        2'b01:   job_cnt <= job_cnt - (AW+1)'(1);
        default: job_cnt <= job_cnt;
      endcase
      if (underrun_set) underrun <= 1'b1;
    end
  end

  assign busy      = (state == ST_SEND) || (state == ST_WAIT);
  assign dbg_state = state;

endmodule

// File: tb/tb_sme_feeder.sv
// -----------------------------------------------------------------------------
// tb_sme_feeder
//   Directed bench for sme_feeder. Inputs are driven 1 time unit after the
//   rising edge; DUT outputs are sampled on the falling edge. A monitor logs
//   every strobed byte as {ispattern,data} into got_q, which tests compare
//   against exp_q.
// -----------------------------------------------------------------------------
module tb_sme_feeder;

  localparam logic [1:0] ST_FIRST = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, underrun, err_len;
  logic [1:0] dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  sme_feeder_if bus();

  sme_feeder #(.DEPTH(64), .STR_MAX(32), .PAT_MAX(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .underrun  (underrun),
    .err_len   (err_len),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.sme_valid     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.sme_isstring || bus.sme_ispattern)
      got_q.push_back({bus.sme_ispattern, bus.sme_chardata});
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic p, input logic l);
    int t;
    bus.in_valid      = 1'b1;
    bus.in_data       = d;
    bus.in_is_pattern = p;
    bus.in_last       = l;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      n_vec++; n_fail++;
      $display("FAIL push_timeout byte=%h in_ready stuck at 0 (expected 1)", d);
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_is_pattern = 1'b0;
    bus.in_last = 1'b0;  bus.sme_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata} !== 10'h000) begin n_fail++; $display("FAIL reset_sme got=%h exp=000", {bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata}); end
    n_vec++; if ({busy, underrun, err_len} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, underrun, err_len}); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_vec++; if (dbg_state !== ST_FIRST) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_FIRST); end
    idle(1);
  endtask

  // "abc" string + "b" pattern: burst starts the cycle after the last write.
  task automatic test_burst();
    logic [9:0] exp_c [4];
    logic [9:0] got;
    exp_c[0] = 10'h261; exp_c[1] = 10'h262; exp_c[2] = 10'h263; exp_c[3] = 10'h162;
    push_byte("a", 1'b0, 1'b0);
    push_byte("b", 1'b0, 1'b0);
    push_byte("c", 1'b0, 1'b0);
    push_byte("b", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata};
      n_vec++; if (got !== exp_c[i]) begin n_fail++; $display("FAIL burst_cycle%0d got=%h exp=%h", i, got, exp_c[i]); end
    end
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern} !== 2'b00) begin n_fail++; $display("FAIL burst_gap got=%b exp=00", {bus.sme_isstring, bus.sme_ispattern}); end
    n_vec++; if ({busy, dbg_state} !== {1'b1, ST_WAIT}) begin n_fail++; $display("FAIL burst_wait got=%b exp=%b", {busy, dbg_state}, {1'b1, ST_WAIT}); end
    @(posedge clk); #1;
  endtask

  // Next job is held until sme_valid, then appears in the valid cycle itself.
  task automatic test_next_on_valid();
    push_byte("c", 1'b1, 1'b1);
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern} !== 2'b00) begin n_fail++; $display("FAIL hold_before_valid got=%b exp=00", {bus.sme_isstring, bus.sme_ispattern}); end
    @(posedge clk); #1 bus.sme_valid = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata} !== 10'h163) begin n_fail++; $display("FAIL valid_same_cycle got=%h exp=163", {bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata}); end
    @(posedge clk); #1 bus.sme_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata} !== 10'h000) begin n_fail++; $display("FAIL after_single got=%h exp=000", {bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata}); end
    n_vec++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL single_to_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
    @(posedge clk); #1;
  endtask

  // sme_valid in WAIT with an empty FIFO -> underrun, then auto-start.
  task automatic test_underrun();
    bus.sme_valid = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern} !== 2'b00) begin n_fail++; $display("FAIL underrun_strobe got=%b exp=00", {bus.sme_isstring, bus.sme_ispattern}); end
    @(posedge clk); #1 bus.sme_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({underrun, busy, dbg_state} !== {1'b1, 1'b0, ST_FIRST}) begin n_fail++; $display("FAIL underrun_flag got=%b exp=%b", {underrun, busy, dbg_state}, {1'b1, 1'b0, ST_FIRST}); end
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    push_byte("x", 1'b0, 1'b0);
    push_byte("y", 1'b1, 1'b1);
    exp_q.push_back({1'b0, 8'h78});
    exp_q.push_back({1'b1, 8'h79});
    idle(5);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL underrun_job_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL underrun_job_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]); end
    end
    n_vec++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
  endtask

`ifdef SME_FEEDER_CHECK_EN
  task automatic test_check_en();
    apply_reset();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i), 1'b1, (i == 9));
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
    idle(12);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pat_trunc_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pat_trunc_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]); end
    end
    n_vec++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL pat_err_len got=%b exp=1", err_len); end

    apply_reset();
    n_vec++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL err_len_cleared got=%b exp=0", err_len); end
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++) push_byte(8'h41 + 8'(i), 1'b0, 1'b0);
    push_byte("P", 1'b1, 1'b1);
    for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, 8'h41 + 8'(i)});
    exp_q.push_back({1'b1, 8'h50});
    idle(40);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL str_trunc_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL str_trunc_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]); end
    end
    n_vec++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL str_err_len got=%b exp=1", err_len); end
  endtask
`else
  // 64 buffered bytes with no complete job: FIFO full, SME left idle.
  task automatic test_full();
    apply_reset();
    got_q.delete();
    for (int i = 0; i < 64; i++) push_byte(8'h6b, 1'b0, 1'b0);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    idle(3);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold got=%b exp=0", bus.in_ready); end
    n_vec++; if (got_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_no_activity got=%0d/%b exp=0/0", got_q.size(), busy); end
    apply_reset();
    n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reset_ready got=%b exp=1", bus.in_ready); end
  endtask

  // Without length checking a 10-byte pattern passes through untouched.
  task automatic test_no_check();
    apply_reset();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i), 1'b1, (i == 9));
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
    idle(12);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL nochk_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nochk_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]); end
    end
    n_vec++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL nochk_err_len got=%b exp=0", err_len); end
  endtask
`endif

  // Reset in the middle of a 32-byte string burst.
  task automatic test_reset_mid_send();
    apply_reset();
    for (int i = 0; i < 32; i++) push_byte(8'h61 + 8'(i % 26), 1'b0, 1'b0);
    push_byte("Q", 1'b1, 1'b1);
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata} !== 10'h000) begin n_fail++; $display("FAIL midrst_sme got=%h exp=000", {bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata}); end
    n_vec++; if ({bus.in_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL midrst_flags got=%b exp=10", {bus.in_ready, busy}); end
    @(posedge clk); #1 reset = 1'b0;
    got_q.delete(); exp_q.delete();
    idle(10);
    n_vec++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_quiet got=%0d exp=0", got_q.size()); end
    push_byte("z", 1'b1, 1'b1);
    exp_q.push_back({1'b1, 8'h7a});
    idle(4);
    n_vec++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midrst_restart got=%0d/%h exp=1/%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1ff, exp_q[0]); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_burst();
    test_next_on_valid();
    test_underrun();
`ifdef SME_FEEDER_CHECK_EN
    test_check_en();
`else
    test_full();
    test_no_check();
`endif
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
